// File: rtl/dmem_pkg.sv
// Shared types and the byte-lane merge helper for the byte-enabled data memory.
// DMEM_DATA_W fixes the record and merge widths; byteen_dmem defaults its DATA_W to it.
package dmem_pkg;

  localparam int DMEM_DATA_W = 32;

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  typedef struct packed {
    logic [31:0]            pc;
    logic [31:0]            addr;
    logic [DMEM_DATA_W-1:0] data;
  } trace_rec_t;

  function automatic logic [DMEM_DATA_W-1:0] merge_bytes(
    input logic [DMEM_DATA_W-1:0]   old_word,
    input logic [DMEM_DATA_W-1:0]   wdata,
    input logic [DMEM_DATA_W/8-1:0] byteen
  );
    logic [DMEM_DATA_W-1:0] res;
    res = old_word;
    for (int k = 0; k < DMEM_DATA_W/8; k++) begin
      if (byteen[k]) res[8*k +: 8] = wdata[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding merged-store trace records; a push into a full FIFO
// (with no simultaneous pop) is dropped and sets the sticky drop_ovf flag.
module trace_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             drop_ovf,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: every output of this block is assigned before any condition, so no latch is inferred.
  always_comb begin
    valid    = wr_ptr_q != rd_ptr_q;
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && valid;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    ovf_d    = ovf_q | (push && !do_push);
    head     = valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    drop_ovf = ovf_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/byteen_dmem.sv
// Byte-enabled data memory for the M stage: zero-sweep after reset, range check,
// lane merge on store, and a buffered valid/ready trace of every committed store.
module byteen_dmem
  import dmem_pkg::*;
#(
  parameter int          DATA_W      = DMEM_DATA_W,
  parameter int          DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          TRACE_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         m_data_addr,
  input  logic [DATA_W-1:0]   m_data_wdata,
  input  logic [DATA_W/8-1:0] m_data_byteen,
  input  logic [31:0]         m_inst_addr,
  output logic [DATA_W-1:0]   m_data_rdata,
  output logic                busy,
  output logic                err_oor,
  output logic                trace_valid,
  input  logic                trace_ready,
  output logic [31:0]         trace_pc,
  output logic [31:0]         trace_addr,
  output logic [DATA_W-1:0]   trace_data,
  output logic                trace_ovf
);

  localparam int NB  = DATA_W / 8;
  localparam int OFS = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [IW-1:0]     sweep_q, sweep_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [31:0]       offset;
  logic [IW-1:0]     idx;
  logic              in_range, run, wr_any;
  logic [DATA_W-1:0] stored, merged;
  logic              mem_we;
  logic [IW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              push, fifo_full;
  trace_rec_t        rec, head;

  always_comb begin
    offset    = m_data_addr - BASE_ADDR;
    in_range  = (m_data_addr >= BASE_ADDR) && ((offset >> OFS) < 32'(DEPTH));
    idx       = offset[OFS +: IW];
    stored    = mem_q[idx];
    run       = state_q == RUN;
    wr_any    = |m_data_byteen;
    merged    = merge_bytes(stored, m_data_wdata, m_data_byteen);
    push      = run && wr_any && in_range;
    err_d     = run && wr_any && !in_range;
    state_d   = state_q;
    sweep_d   = sweep_q;
    mem_we    = push;
    mem_waddr = idx;
    mem_wdata = merged;
    if (!run) begin
      // Sweep owns the write port; store traffic is ignored until RUN.
      mem_we    = 1'b1;
      mem_waddr = sweep_q;
      mem_wdata = '0;
      sweep_d   = sweep_q + 1'b1;
      if (sweep_q == IW'(DEPTH - 1)) state_d = RUN;
    end
    m_data_rdata = (run && in_range) ? stored : '0;
    busy         = !run;
    err_oor      = err_q;
    rec.pc       = m_inst_addr;
    rec.addr     = m_data_addr & ~32'(NB - 1);
    rec.data     = merged;
    trace_pc     = head.pc;
    trace_addr   = head.addr;
    trace_data   = head.data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      sweep_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  trace_fifo #(
    .WIDTH($bits(trace_rec_t)),
    .DEPTH(TRACE_DEPTH)
  ) u_trace_fifo (
    .clk      (clk),
    .rst      (reset),
    .push     (push),
    .push_data(rec),
    .full     (fifo_full),
    .drop_ovf (trace_ovf),
    .pop      (trace_ready),
    .valid    (trace_valid),
    .head     (head)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: doc/byteen_dmem.md
# byteen_dmem

Parametrised, synthesizable byte-enabled data memory for the pipelined CPU's M stage, with a hardware zero-sweep after reset and a buffered write-trace port. Replaces the behavioural data array and write-merge logic in the simulation top. Merged store records (`pc`, aligned address, merged word) are queued in a small FIFO so the trace logger drains them with a valid/ready handshake instead of sampling the store bus directly.

## Interface
- `DATA_W`, default 32: word width; must be a multiple of 8; `NB = DATA_W/8` byte lanes.
- `DEPTH`, default 4096: number of words; power of two.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0.
- `TRACE_DEPTH`, default 8: trace FIFO entries; power of two, at least 2.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `m_data_addr` input 32: byte address; the low `log2(NB)` bits are ignored.
- `m_data_wdata` input DATA_W: store data, lane-aligned.
- `m_data_byteen` input NB: per-lane write enable; all zero means no write.
- `m_inst_addr` input 32: PC of the store, recorded in the trace.
- `m_data_rdata` output DATA_W: combinational read of the addressed word.
- `busy` output 1: high while reset is asserted and during the clear sweep.
- `err_oor` output 1: one-cycle pulse when a write falls outside the memory range.
- `trace_valid` output 1: head trace record is valid.
- `trace_ready` input 1: consumer accepts the head record.
- `trace_pc` output 32: PC field of the head record.
- `trace_addr` output 32: word-aligned byte address field of the head record.
- `trace_data` output DATA_W: merged word field of the head record.
- `trace_ovf` output 1: sticky flag, set when a record is dropped; cleared only by reset.

## Operation
- States are CLEAR and RUN. Reset forces CLEAR and sets the sweep index to 0.
- CLEAR:
  - Writes zero to word[index] each cycle; `busy=1`.
  - After writing word `DEPTH-1`, goes to RUN on the next edge.
  - Incoming writes are dropped with no trace record; `m_data_rdata=0`.
- RUN:
  - Word index is `(m_data_addr - BASE_ADDR) >> log2(NB)`.
  - An address is in range when `m_data_addr >= BASE_ADDR` and the index is less than `DEPTH`.
- Write, when `|m_data_byteen` and in range:
  - merged = stored word, with lane k replaced by `m_data_wdata[8k+7:8k]` wherever `m_data_byteen[k]` is set.
  - The merged word is committed at the edge.
  - A record {`m_inst_addr`, aligned address, merged} is pushed to the FIFO.
- Write, when `|m_data_byteen` and out of range:
  - No memory change and no trace record.
  - `err_oor=1` for the following cycle.
- Read: `m_data_rdata` = stored word at the index when in range, otherwise 0.
- FIFO push when full: the record is dropped, `trace_ovf` is set, and the memory write still commits.
- FIFO pop when `trace_valid && trace_ready`.
- Push and pop in the same cycle while full: the pop frees a slot and the push is accepted. Count is unchanged; no overflow.
- Pointers have `log2(TRACE_DEPTH)+1` bits.
  - Full: MSBs differ and the remaining bits are equal.
  - Empty: pointers are equal.
  - Pointers wrap naturally.

## Timing
- Reset values:
  - `busy=1`, `err_oor=0`, `trace_valid=0`, `trace_ovf=0`.
  - `trace_pc`/`trace_addr`/`trace_data` are 0 while the FIFO is empty.
  - FIFO pointers are 0; state is CLEAR.
- Clear sweep takes exactly `DEPTH` cycles after reset deasserts. `busy` falls on the edge that enters RUN.
- Reset asserted mid-sweep or mid-run: restarts the sweep from index 0 and empties the FIFO. Memory contents are not reset asynchronously; the sweep zeroes them.
- Read-during-write to the same word: `m_data_rdata` shows the old word in that cycle and the new word from the next cycle.
- Trace latency: a record pushed at edge N gives `trace_valid=1` after edge N, when the FIFO was empty. There is no fall-through in the same cycle.
- `trace_*` fields hold stable while `trace_valid && !trace_ready`.
- `err_oor` is registered and lasts exactly one cycle per offending write. Back-to-back offending writes keep it high.

## Structure
- Package `dmem_pkg` holds:
  - `state_e` {CLEAR, RUN};
  - `trace_rec_t` struct {pc, addr, data}, parametrised via `DATA_W` localparam defaults;
  - function `merge_bytes(old, wdata, byteen)`.
- Sub-module `trace_fifo`:
  - parameters WIDTH and DEPTH; synchronous FIFO with async reset;
  - ports push/full/drop_ovf, pop/valid/head.
- Top contains the memory array, sweep counter/FSM, range check and merge.

## Test plan
- Reset for 3 cycles, then release with `DEPTH=16` -> `busy` stays high for exactly 16 cycles; every read returns 0 afterwards; a write during the sweep has no effect and produces no trace record.
- Write to 0x4 with data 0xAABBCCDD and byteen 1111, then data 0x00001122 with byteen 0011 -> word reads 0xAABB1122; second record is {pc, 0x4, 0xAABB1122}.
- Write with byteen 0100 and data 0x00EE0000 at address 0x9 -> addr treated as 0x8; trace_addr=0x8; only bits [23:16] change.
- `DEPTH=16`, `BASE_ADDR=0x1000`, write to 0x0FFC and then to 0x1040 -> `err_oor` pulses once per write; memory is unchanged; the FIFO stays empty.
- `TRACE_DEPTH=4`, `trace_ready=0`, 5 writes -> 4 records held; `trace_ovf=1`; 5th word committed. Then raise `trace_ready` together with a 6th write -> records drain in order and the 6th is accepted.
- Assert reset mid-run while the FIFO is non-empty -> `trace_valid=0` and `busy=1` immediately; after release a full sweep runs and prior data reads 0.
